// File: rtl/dpram_fifo_ctrl.sv
// Pointer/level/flag controller that turns a one-write/one-read DualPortRAM
// with a registered read port into a synchronous FIFO of depth 2**Addr_Width.
module dpram_fifo_ctrl #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Addr_Width = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic                  wr_ena,
  output logic [Addr_Width-1:0] Wr_addr,
  output logic [Addr_Width-1:0] Re_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [Addr_Width:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** Addr_Width;
  localparam int unsigned LvlW  = Addr_Width + 1;

  // The data path lives entirely in the RAM; the word width only has to be sane.
  if (Data_Width < 1) begin : g_bad_data_width
    $error("dpram_fifo_ctrl: Data_Width must be at least 1");
  end

  logic [Addr_Width-1:0] r_wr_ptr;
  logic [Addr_Width-1:0] r_rd_ptr;
  logic [LvlW-1:0]       r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [LvlW-1:0]       w_level_nxt;

  // Full blocks push even with a pop present, so the RAM never reads and writes one address.
  assign w_push_acc = push & ~r_full;
  assign w_pop_acc  = pop & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push_acc, w_pop_acc})
      2'b10:   w_level_nxt = r_level + LvlW'(1);
      2'b01:   w_level_nxt = r_level - LvlW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + Addr_Width'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + Addr_Width'(1);
      r_level     <= w_level_nxt;
      r_full      <= (w_level_nxt == LvlW'(Depth));
      r_empty     <= (w_level_nxt == '0);
      r_rd_valid  <= w_pop_acc;
      // A new error in the clearing cycle keeps the flag set.
      r_overflow  <= (push & r_full)  | (r_overflow  & ~clr_err);
      r_underflow <= (pop  & r_empty) | (r_underflow & ~clr_err);
    end
  end

  assign wr_ena    = w_push_acc & rst_n;
  assign Wr_addr   = r_wr_ptr;
  assign Re_addr   = r_rd_ptr;
  assign rd_valid  = r_rd_valid;
  assign full      = r_full;
  assign empty     = r_empty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: directed vector table, async-reset sequence and
// randomized traffic against a queue-based FIFO reference, with a RAM model.
module tb_dpram_fifo_ctrl;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rst_n, push, pop, clr_err;
  logic          wr_ena, rd_valid, full, empty, overflow, underflow;
  logic [AW-1:0] Wr_addr, Re_addr;
  logic [AW:0]   level;
  logic [DW-1:0] din;
  logic [DW-1:0] mem [D];
  logic [DW-1:0] data_read;

  int n_checks = 0;
  int n_fail   = 0;

  dpram_fifo_ctrl #(.Data_Width(DW), .Addr_Width(AW)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr_err(clr_err),
    .wr_ena(wr_ena), .Wr_addr(Wr_addr), .Re_addr(Re_addr), .rd_valid(rd_valid),
    .full(full), .empty(empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // DualPortRAM: write port plus registered read port.
  always @(posedge clk) begin
    if (wr_ena) mem[Wr_addr] <= din;
    data_read <= mem[Re_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit push, pop, clr; logic [7:0] d;
    bit we; int wa, ra;
    int lvl; bit full, empty, ovf, unf, rdv; logic [7:0] rd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit p, bit q, bit c, int d, bit we, int wa, int ra,
                              int lvl, bit f, bit e, bit ov, bit un, bit rv, int rd);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.d = 8'(d);
    v.we = we; v.wa = wa; v.ra = ra;
    v.lvl = lvl; v.full = f; v.empty = e; v.ovf = ov; v.unf = un; v.rdv = rv; v.rd = 8'(rd);
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic drive(input bit p, input bit q, input bit c, input logic [7:0] d);
    push = p; pop = q; clr_err = c; din = d;
    @(posedge clk); #1;
  endtask

  // Reference FIFO state
  logic [7:0] m_q[$];
  int m_wcnt, m_rcnt;
  bit m_ovf, m_unf, m_rdv;
  logic [7:0] m_rd;

  task automatic model_reset();
    m_q.delete(); m_wcnt = 0; m_rcnt = 0; m_ovf = 0; m_unf = 0; m_rdv = 0; m_rd = '0;
  endtask

  task automatic rand_step(input int push_pct, input int pop_pct);
    bit was_full, was_empty, pacc, racc;
    push = ($urandom_range(0, 99) < push_pct);
    pop  = ($urandom_range(0, 99) < pop_pct);
    clr_err = ($urandom_range(0, 19) == 0);
    din = 8'($urandom);
    was_full  = (m_q.size() == D);
    was_empty = (m_q.size() == 0);
    pacc = push && !was_full;
    racc = pop && !was_empty;
    #1;
    check("rnd wr_ena", 32'(wr_ena), 32'(pacc));
    check("rnd Wr_addr", 32'(Wr_addr), 32'(m_wcnt % D));
    check("rnd Re_addr", 32'(Re_addr), 32'(m_rcnt % D));
    @(posedge clk); #1;
    m_rdv = racc;
    if (racc) begin m_rd = m_q.pop_front(); m_rcnt++; end
    if (pacc) begin m_q.push_back(din); m_wcnt++; end
    m_ovf = (push && was_full)  || (m_ovf && !clr_err);
    m_unf = (pop  && was_empty) || (m_unf && !clr_err);
    check("rnd level", 32'(level), 32'(m_q.size()));
    check("rnd full", 32'(full), 32'(m_q.size() == D));
    check("rnd empty", 32'(empty), 32'(m_q.size() == 0));
    check("rnd rd_valid", 32'(rd_valid), 32'(m_rdv));
    check("rnd overflow", 32'(overflow), 32'(m_ovf));
    check("rnd underflow", 32'(underflow), 32'(m_unf));
    if (m_rdv) check("rnd data_read", 32'(data_read), 32'(m_rd));
  endtask

  initial begin
    // Fill, overflow, drain, underflow, clear, boundary simultaneity, wrap.
    add(1,0,0, 6, 1,0,0, 1,0,0,0,0,0,0);
    add(1,0,0, 5, 1,1,0, 2,0,0,0,0,0,0);
    add(1,0,0, 4, 1,2,0, 3,0,0,0,0,0,0);
    add(1,0,0, 3, 1,3,0, 4,1,0,0,0,0,0);
    add(1,0,0, 9, 0,0,0, 4,1,0,1,0,0,0);
    add(0,1,0, 0, 0,0,0, 3,0,0,1,0,1,6);
    add(0,1,0, 0, 0,0,1, 2,0,0,1,0,1,5);
    add(0,1,0, 0, 0,0,2, 1,0,0,1,0,1,4);
    add(0,1,0, 0, 0,0,3, 0,0,1,1,0,1,3);
    add(0,1,0, 0, 0,0,0, 0,0,1,1,1,0,0);
    add(0,0,1, 0, 0,0,0, 0,0,1,0,0,0,0);
    add(1,1,0, 7, 1,0,0, 1,0,0,0,1,0,0);
    add(1,0,0, 8, 1,1,0, 2,0,0,0,1,0,0);
    add(1,0,0,10, 1,2,0, 3,0,0,0,1,0,0);
    add(1,0,0,11, 1,3,0, 4,1,0,0,1,0,0);
    add(1,1,0,12, 0,0,0, 3,0,0,1,1,1,7);
    add(0,1,1, 0, 0,0,1, 2,0,0,0,0,1,8);
    add(1,0,0,13, 1,0,2, 3,0,0,0,0,0,0);
    add(1,0,0,14, 1,1,2, 4,1,0,0,0,0,0);
    add(1,0,1,15, 0,2,2, 4,1,0,1,0,0,0);
    add(0,0,1, 0, 0,2,2, 4,1,0,0,0,0,0);
    add(0,1,0, 0, 0,2,2, 3,0,0,0,0,1,10);
    add(0,1,0, 0, 0,2,3, 2,0,0,0,0,1,11);
    for (int k = 0; k < 6; k++)
      add(1,1,0, 20+k, 1,(2+k)%4,k%4, 2,0,0,0,0,1, (k == 0) ? 13 : (k == 1) ? 14 : 18+k);

    do_reset();
    #1;
    check("rst empty", 32'(empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst level", 32'(level), 32'd0);
    check("rst Wr_addr", 32'(Wr_addr), 32'd0);
    check("rst Re_addr", 32'(Re_addr), 32'd0);
    check("rst wr_ena", 32'(wr_ena), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst underflow", 32'(underflow), 32'd0);

    foreach (tbl[i]) begin
      push = tbl[i].push; pop = tbl[i].pop; clr_err = tbl[i].clr; din = tbl[i].d;
      #1;
      check($sformatf("vec%0d wr_ena", i), 32'(wr_ena), 32'(tbl[i].we));
      check($sformatf("vec%0d Wr_addr", i), 32'(Wr_addr), 32'(tbl[i].wa));
      check($sformatf("vec%0d Re_addr", i), 32'(Re_addr), 32'(tbl[i].ra));
      @(posedge clk); #1;
      check($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].lvl));
      check($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].full));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].empty));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(tbl[i].unf));
      check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rdv));
      if (tbl[i].rdv) check($sformatf("vec%0d data_read", i), 32'(data_read), 32'(tbl[i].rd));
    end

    // Asynchronous reset between edges with a pop result pending.
    do_reset();
    drive(1, 0, 0, 8'h21);
    drive(1, 0, 0, 8'h22);
    drive(1, 1, 0, 8'h23);
    check("pre-arst rd_valid", 32'(rd_valid), 32'd1);
    check("pre-arst level", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst level", 32'(level), 32'd0);
    check("arst empty", 32'(empty), 32'd1);
    check("arst full", 32'(full), 32'd0);
    check("arst rd_valid", 32'(rd_valid), 32'd0);
    check("arst wr_ena", 32'(wr_ena), 32'd0);
    check("arst Wr_addr", 32'(Wr_addr), 32'd0);
    check("arst Re_addr", 32'(Re_addr), 32'd0);
    push = 1'b0; pop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    push = 1'b1; din = 8'h55;
    #1;
    check("post-arst wr_ena", 32'(wr_ena), 32'd1);
    check("post-arst Wr_addr", 32'(Wr_addr), 32'd0);
    @(posedge clk); #1;
    check("post-arst level", 32'(level), 32'd1);
    push = 1'b0; pop = 1'b1;
    @(posedge clk); #1;
    check("post-arst rd_valid", 32'(rd_valid), 32'd1);
    check("post-arst data_read", 32'(data_read), 32'h55);

    // Randomized traffic against the queue reference, with fill- and drain-biased phases.
    do_reset();
    model_reset();
    for (int i = 0; i < 150; i++) rand_step(50, 50);
    for (int i = 0; i < 100; i++) rand_step(85, 25);
    for (int i = 0; i < 100; i++) rand_step(25, 85);
    for (int i = 0; i < 150; i++) rand_step(60, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Pointer/flag controller that turns the DualPortRAM (one write port, one read port, registered read) into a synchronous FIFO of depth 2**Addr_Width.
- Accepts push/pop requests and drives the RAM's wr_ena, Wr_addr and Re_addr.
- Reports full/empty/level, a read-data-valid strobe aligned to the RAM's registered Data_read, and sticky overflow/underflow error flags.
- Write data goes directly to the RAM's Data_write and does not pass through this block.

Parameters:
Data_Width, 8, width of RAM word. Used only for consistency checks; no data path inside the block.
Addr_Width, 2, RAM address width; FIFO depth = 2**Addr_Width (default 4).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
push  input  1  write request for this cycle.
pop  input  1  read request for this cycle.
clr_err  input  1  synchronous clear of the sticky error flags.
wr_ena  output  1  RAM write enable. Combinational; equals push_acc.
Wr_addr  output  Addr_Width  RAM write address. Equals the write pointer.
Re_addr  output  Addr_Width  RAM read address. Equals the read pointer.
rd_valid  output  1  registered; RAM Data_read holds the popped word this cycle.
full  output  1  registered; level == 2**Addr_Width.
empty  output  1  registered; level == 0.
level  output  Addr_Width+1  registered; number of stored entries.
overflow  output  1  sticky; a push was rejected.
underflow  output  1  sticky; a pop was rejected.

Behaviour:
- Reset (rst_n low, asynchronous assert, registers clear immediately):
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - empty = 1, full = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - wr_ena = 0 while in reset.
- Acceptance:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - When full, a push is rejected even if pop is also high. This avoids a read-during-write on the same RAM address.
  - When empty, a pop is rejected even if push is also high. There is no write-through bypass.
- Pointers (Addr_Width bits, natural wrap-around 2**Addr_Width-1 -> 0):
  - wr_ptr increments on push_acc.
  - rd_ptr increments on pop_acc.
- Level:
  - +1 on push_acc only; -1 on pop_acc only; unchanged when both or neither are accepted.
  - full and empty are registered from the next-state level.
- Write timing: wr_ena is high in the same cycle as push_acc. The RAM captures Data_write at Wr_addr = wr_ptr on that edge.
- Read timing:
  - Re_addr = rd_ptr is presented in the pop cycle; the RAM registers Data_read at that edge.
  - rd_valid <= pop_acc, so it pulses exactly one cycle after an accepted pop.
  - Read latency is 1 clock. Back-to-back pops give a continuous rd_valid.
- Simultaneous push_acc and pop_acc (0 < level < depth): both pointers advance and level is unchanged. The addresses differ, so there is no RAM conflict.
- Error flags:
  - overflow sets on push & full; underflow sets on pop & empty.
  - Both hold until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, set wins.
- Reset mid-operation: all stored entries are logically discarded (the RAM contents are not cleared). A pending rd_valid is dropped.
- No state machine beyond the pointer/level registers. The block must be fully synchronous apart from the asynchronous reset.

Test Plan:
- Reset: rst_n low for 2 cycles, then release with no requests -> empty=1, full=0, level=0, Wr_addr=0, Re_addr=0, wr_ena=0, flags=0.
- Fill: push 4 consecutive cycles with data 6,5,4,3 -> wr_ena high with Wr_addr 0,1,2,3; level 1..4; full=1 after the 4th edge. A 5th push -> wr_ena=0, overflow=1, level stays 4.
- Drain: pop 4 cycles -> Re_addr 0,1,2,3; rd_valid high in cycles 2..5 with Data_read 6,5,4,3; empty=1 at end. A 5th pop -> underflow=1, no rd_valid.
- Wrap and simultaneous: preload 2 entries, then push and pop together for 6 cycles -> level stays 2; Wr_addr sequence 2,3,0,1,2,3; data order preserved.
- Boundary simultaneity: push&pop when empty -> only the push is accepted, level=1, underflow=1. Push&pop when full -> only the pop is accepted, level=3, overflow=1. clr_err -> both flags 0 next cycle.
- Async reset mid-burst: assert rst_n low between edges during the fill -> outputs go to reset values immediately, without waiting for a clock edge; after release, a push writes to address 0.
